// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture writer.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_LOW  = 4'b0011;

    localparam int DEFAULT_DEPTH    = 10000;
    localparam int DEFAULT_ADDR_W   = 14;
    localparam int DEFAULT_SAMPLE_W = 12;

endpackage

// File: rtl/adc_capture_writer_packer.sv
// Packs pairs of ADC samples into 32-bit words: first sample low half, second
// sample high half. word_valid/word are combinational so the top can register
// the write one cycle after the completing sample.
module adc_sample_packer
    import adc_capture_pkg::*;
#(
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                flush,
    output logic                word_valid,
    output logic [31:0]         word,
    output logic                half_pending
);

    logic [15:0] low_half;
    logic [15:0] sample_ext;

    assign sample_ext = 16'(sample);

    // Hold the first sample of a pair and track whether a half-word is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_pending <= 1'b0;
            low_half     <= '0;
        end else if (clear) begin
            half_pending <= 1'b0;
        end else if (flush && half_pending) begin
            half_pending <= 1'b0;
        end else if (valid) begin
            if (half_pending) begin
                half_pending <= 1'b0;
            end else begin
                half_pending <= 1'b1;
                low_half     <= sample_ext;
            end
        end
    end

    // A word is ready when the second sample arrives or a pending half is forced out.
    always_comb begin
        word_valid = half_pending && (valid || flush);
        if (flush) begin
            word = {16'h0000, low_half};
        end else begin
            word = {sample_ext, low_half};
        end
    end

endmodule

// File: rtl/adc_capture_writer.sv
// ADC capture stage: packs sample pairs and writes them to consecutive word
// addresses through a write-only Avalon-MM master, single-shot or ring mode.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CAPTURE | accepting samples and writing packed words
// FLUSH   | forcing out a pending half-word after stop
// DONE    | capture finished, waiting for the next start
module adc_capture_writer
    import adc_capture_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                ring_mode,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [3:0]          avm_byteenable,
    output logic [31:0]         avm_writedata,
    output logic                busy,
    output logic                done,
    output logic                wrapped,
    output logic [ADDR_W-1:0]   wr_ptr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t      state, next_state;
    logic        ring_q;
    // drain: the write currently being issued is the final one; drop new samples
    logic        drain;
    logic        drain_set;
    logic        start_go;
    logic        accept;
    logic        flush;
    logic        pend_after;
    logic        last_word;
    logic        word_valid;
    logic        half_pending;
    logic [31:0] word;

    assign accept     = (state == CAPTURE) && !drain && sample_valid;
    assign flush      = (state == FLUSH) && half_pending;
    assign pend_after = half_pending ^ accept;

    adc_sample_packer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_packer (
        .clk          (clk),
        .rst          (reset),
        .clear        (start_go),
        .valid        (accept),
        .sample       (sample_data),
        .flush        (flush),
        .word_valid   (word_valid),
        .word         (word),
        .half_pending (half_pending)
    );

    assign last_word = word_valid && !ring_q && (wr_ptr == LAST_ADDR);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, start qualification and end-of-capture detection.
    always_comb begin
        next_state = state;
        drain_set  = 1'b0;
        start_go   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = CAPTURE;
                    start_go   = 1'b1;
                end
            end
            CAPTURE: begin
                if (drain) begin
                    next_state = DONE;
                end else if (stop) begin
                    if (pend_after) begin
                        next_state = FLUSH;
                    end else if (word_valid) begin
                        drain_set = 1'b1;
                    end else begin
                        next_state = DONE;
                    end
                end else if (last_word) begin
                    drain_set = 1'b1;
                end
            end
            FLUSH: begin
                if (!half_pending) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pointer, mode latch and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wrapped <= 1'b0;
            wr_ptr  <= '0;
            ring_q  <= 1'b0;
            drain   <= 1'b0;
        end else begin
            busy  <= (next_state == CAPTURE) || (next_state == FLUSH);
            drain <= ((state == CAPTURE) && (next_state == CAPTURE)) ? (drain | drain_set) : 1'b0;
            if (start_go) begin
                ring_q  <= ring_mode;
                done    <= 1'b0;
                wrapped <= 1'b0;
                wr_ptr  <= '0;
            end else begin
                if (avm_write) begin
                    if (wr_ptr == LAST_ADDR) begin
                        wr_ptr <= '0;
                        if (ring_q) begin
                            wrapped <= 1'b1;
                        end
                    end else begin
                        wr_ptr <= wr_ptr + ADDR_ONE;
                    end
                end
                if ((next_state == DONE) && (state != DONE)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Registered Avalon-MM write port; idle cycles drive all zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
        end else begin
            avm_write      <= word_valid;
            avm_chipselect <= word_valid;
            avm_address    <= word_valid ? wr_ptr : '0;
            avm_byteenable <= word_valid ? (flush ? BE_LOW : BE_FULL) : 4'b0000;
            avm_writedata  <= word_valid ? word : 32'h0;
        end
    end

endmodule

// File: tb/tb_adc_capture_writer.sv
// Directed bench for adc_capture_writer with a small DEPTH.
module tb_adc_capture_writer;

    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 14;
    localparam int SAMPLE_W = 12;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                ring_mode = 1'b0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data = '0;
    logic                avm_chipselect;
    logic                avm_write;
    logic [ADDR_W-1:0]   avm_address;
    logic [3:0]          avm_byteenable;
    logic [31:0]         avm_writedata;
    logic                busy;
    logic                done;
    logic                wrapped;
    logic [ADDR_W-1:0]   wr_ptr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        wrap;
        logic        cs;
    } wr_t;

    wr_t log_q[$];

    adc_capture_writer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .ring_mode      (ring_mode),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .busy           (busy),
        .done           (done),
        .wrapped        (wrapped),
        .wr_ptr         (wr_ptr)
    );

    always #5 clk = ~clk;

    // Record every write cycle seen on the bus.
    always @(negedge clk) begin
        if (avm_write) begin
            log_q.push_back('{addr: 32'(avm_address), data: avm_writedata,
                              be: avm_byteenable, wrap: wrapped, cs: avm_chipselect});
        end
    end

    function automatic wr_t get_wr(input int i);
        wr_t w;
        w.addr = 32'hDEAD_BEEF;
        w.data = 32'hDEAD_BEEF;
        w.be   = 4'hx;
        w.wrap = 1'bx;
        w.cs   = 1'bx;
        if (i < log_q.size()) w = log_q[i];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SAMPLE_W-1:0] v);
        sample_valid = 1'b1;
        sample_data  = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic r);
        ring_mode = r;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_write"}, 32'(avm_write), 32'd0);
        check({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
        check({tag, "_addr"}, 32'(avm_address), 32'd0);
        check({tag, "_be"}, 32'(avm_byteenable), 32'd0);
        check({tag, "_data"}, avm_writedata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_wrapped"}, 32'(wrapped), 32'd0);
        check({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
    endtask

    initial begin
        wr_t w;

        // Reset values
        repeat (3) tick();
        check_quiet("rst");
        reset = 1'b0;
        tick();

        // Single-shot fill of 8 words, then an extra sample that must be dropped
        log_q.delete();
        pulse_start(1'b0);
        check("ss_busy_rise", 32'(busy), 32'd1);
        for (int i = 1; i <= 16; i++) send(SAMPLE_W'(i));
        send(12'h011);
        repeat (3) tick();
        check("ss_nwrites", log_q.size(), 32'd8);
        w = get_wr(0);
        check("ss_addr0", w.addr, 32'd0);
        check("ss_data0", w.data, 32'h0002_0001);
        check("ss_be0", 32'(w.be), 32'hF);
        check("ss_cs0", 32'(w.cs), 32'd1);
        w = get_wr(7);
        check("ss_addr7", w.addr, 32'd7);
        check("ss_data7", w.data, 32'h0010_000F);
        check("ss_be7", 32'(w.be), 32'hF);
        check("ss_done", 32'(done), 32'd1);
        check("ss_busy", 32'(busy), 32'd0);
        check("ss_wr_ptr", 32'(wr_ptr), 32'd0);
        check("ss_wrapped", 32'(wrapped), 32'd0);

        // Ring mode: 20 samples, 10 writes wrapping after address 7
        log_q.delete();
        pulse_start(1'b1);
        check("ring_done_cleared", 32'(done), 32'd0);
        for (int i = 1; i <= 20; i++) send(SAMPLE_W'(i));
        tick();
        check("ring_nwrites", log_q.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            w = get_wr(i);
            check($sformatf("ring_addr%0d", i), w.addr, 32'(i % DEPTH));
        end
        w = get_wr(9);
        check("ring_data9", w.data, 32'h0014_0013);
        w = get_wr(7);
        check("ring_wrap_before", 32'(w.wrap), 32'd0);
        w = get_wr(8);
        check("ring_wrap_after", 32'(w.wrap), 32'd1);
        check("ring_wrapped", 32'(wrapped), 32'd1);
        check("ring_wr_ptr", 32'(wr_ptr), 32'd2);
        check("ring_busy", 32'(busy), 32'd1);
        pulse_stop();
        check("ring_stop_done", 32'(done), 32'd1);
        check("ring_stop_busy", 32'(busy), 32'd0);

        // Stop with a pending half-word forces a low-lane flush write
        log_q.delete();
        pulse_start(1'b0);
        check("stop3_wrapped_cleared", 32'(wrapped), 32'd0);
        send(12'h00A);
        send(12'h00B);
        send(12'h00C);
        pulse_stop();
        check("stop3_busy_flush", 32'(busy), 32'd1);
        tick();
        check("stop3_flush_write", 32'(avm_write), 32'd1);
        check("stop3_done_early", 32'(done), 32'd0);
        tick();
        check("stop3_done", 32'(done), 32'd1);
        check("stop3_busy", 32'(busy), 32'd0);
        check("stop3_wr_ptr", 32'(wr_ptr), 32'd2);
        tick();
        check("stop3_nwrites", log_q.size(), 32'd2);
        w = get_wr(0);
        check("stop3_addr0", w.addr, 32'd0);
        check("stop3_data0", w.data, 32'h000B_000A);
        check("stop3_be0", 32'(w.be), 32'hF);
        w = get_wr(1);
        check("stop3_addr1", w.addr, 32'd1);
        check("stop3_data1", w.data, 32'h0000_000C);
        check("stop3_be1", 32'(w.be), 32'h3);

        // Stop in the same cycle as the second sample: one full word, no flush
        log_q.delete();
        pulse_start(1'b0);
        send(12'h001);
        sample_valid = 1'b1;
        sample_data  = 12'h002;
        stop         = 1'b1;
        tick();
        sample_valid = 1'b0;
        stop         = 1'b0;
        check("stop2_write", 32'(avm_write), 32'd1);
        check("stop2_done_early", 32'(done), 32'd0);
        tick();
        check("stop2_done", 32'(done), 32'd1);
        check("stop2_busy", 32'(busy), 32'd0);
        check("stop2_wr_ptr", 32'(wr_ptr), 32'd1);
        repeat (2) tick();
        check("stop2_nwrites", log_q.size(), 32'd1);
        w = get_wr(0);
        check("stop2_data0", w.data, 32'h0002_0001);
        check("stop2_be0", 32'(w.be), 32'hF);

        // Reset in the cycle after a word completes
        log_q.delete();
        pulse_start(1'b0);
        send(12'h005);
        send(12'h006);
        check("rstmid_write_pre", 32'(avm_write), 32'd1);
        reset = 1'b1;
        #1;
        check_quiet("rstmid");
        repeat (3) tick();
        check("rstmid_nwrites", log_q.size(), 32'd0);
        reset = 1'b0;
        tick();

        // Samples and stop in IDLE are ignored
        sample_valid = 1'b1;
        stop         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_data = SAMPLE_W'(12'h700 + i);
            tick();
        end
        sample_valid = 1'b0;
        stop         = 1'b0;
        tick();
        check("idle_nwrites", log_q.size(), 32'd0);
        check_quiet("idle");

        // Start while busy keeps the pending half and the pointer
        pulse_start(1'b0);
        send(12'h123);
        pulse_start(1'b0);
        send(12'h456);
        repeat (2) tick();
        check("rebusy_nwrites", log_q.size(), 32'd1);
        w = get_wr(0);
        check("rebusy_addr0", w.addr, 32'd0);
        check("rebusy_data0", w.data, 32'h0456_0123);
        check("rebusy_wr_ptr", 32'(wr_ptr), 32'd1);
        check("rebusy_busy", 32'(busy), 32'd1);
        check("rebusy_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
